// File: rtl/htg_ad9213_snapshot_if.sv
// Sample stream and buffer read port of the AD9213 snapshot buffer.
// The master drives the samples and the read address. The slave
// (the snapshot buffer) returns the read data.
interface htg_ad9213_snapshot_if #(
    parameter int ADDR_W = 10,
    parameter int LANES  = 32,
    parameter int SAMP_W = 12
);
    logic [LANES*SAMP_W-1:0] din;
    logic                    din_valid;
    logic [ADDR_W-1:0]       rd_addr;
    logic [LANES*SAMP_W-1:0] rd_data;

    modport master (output din, output din_valid, output rd_addr, input rd_data);
    modport slave  (input din, input din_valid, input rd_addr, output rd_data);
endinterface

// File: rtl/htg_ad9213_snapshot.sv
// Triggered snapshot buffer for one AD9213 FMC.
// While armed, each valid sample word is written into a circular
// block RAM. After a trigger, the buffer keeps writing for a
// programmable number of post-trigger words and then freezes.
// Software reads the frozen words through a read port with a
// latency of two clock cycles.
module htg_ad9213_snapshot #(
    parameter int ADDR_W = 10,
    parameter int LANES  = 32,
    parameter int SAMP_W = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    htg_ad9213_snapshot_if.slave  bus,
    input  logic                  arm,
    input  logic [1:0]            trig_sel,
    input  logic                  trig_ext,
    input  logic [SAMP_W-1:0]     level,
    input  logic [ADDR_W:0]       post_len,
    output logic                  busy,
    output logic                  done,
    output logic                  wrapped,
    output logic [ADDR_W-1:0]     trig_addr
);
    localparam int              WORD_W  = LANES * SAMP_W;
    localparam int              DEPTH_I = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH   = (ADDR_W + 1)'(DEPTH_I);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0]     fill_reg, fill_next;
    logic [ADDR_W:0]     post_cnt_reg, post_cnt_next;
    logic                wrapped_reg, wrapped_next;
    logic [ADDR_W-1:0]   trig_addr_reg, trig_addr_next;
    logic [ADDR_W:0]     eff_len;
    logic                wr_en;
    logic [LANES-1:0]    lane_ge;
    logic                level_hit;
    logic                trig_hit;

    logic [WORD_W-1:0]   mem [0:DEPTH_I-1];
    logic [ADDR_W-1:0]   rd_addr_reg;
    logic [WORD_W-1:0]   rd_data_reg;

    // Level trigger: each lane is compared as a signed value against the threshold.
    // The compare is combinational, so the trigger address is the address
    // of the word that met the condition.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane_cmp
            assign lane_ge[gi] = $signed(bus.din[gi*SAMP_W +: SAMP_W]) >= $signed(level);
        end
    endgenerate
    assign level_hit = |lane_ge;

    // Select the trigger source. Source 3 behaves the same as the external source.
    always_comb begin
        trig_hit = 1'b0;
        case (trig_sel)
            2'd0:    trig_hit = 1'b1;
            2'd2:    trig_hit = level_hit;
            default: trig_hit = trig_ext;
        endcase
    end

    // Limit the post-trigger length to the range 1 .. buffer depth.
    always_comb begin
        eff_len = post_len;
        if (post_len == '0)
            eff_len = ONE_L;
        else if (post_len > DEPTH)
            eff_len = DEPTH;
    end

    // Next-state and datapath logic. An arm pulse overrides everything,
    // including a trigger in the same cycle.
    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        fill_next      = fill_reg;
        post_cnt_next  = post_cnt_reg;
        wrapped_next   = wrapped_reg;
        trig_addr_next = trig_addr_reg;
        wr_en          = 1'b0;
        if (arm) begin
            state_next    = ARMED;
            wr_ptr_next   = '0;
            fill_next     = '0;
            post_cnt_next = '0;
            wrapped_next  = 1'b0;
        end else begin
            case (state_reg)
                ARMED: begin
                    wrapped_next = wrapped_reg | (fill_reg == DEPTH);
                    if (bus.din_valid) begin
                        wr_en       = 1'b1;
                        wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
                        if (fill_reg != DEPTH)
                            fill_next = fill_reg + ONE_L;
                        if (trig_hit) begin
                            trig_addr_next = wr_ptr_reg;
                            post_cnt_next  = eff_len - ONE_L;
                            state_next     = (eff_len == ONE_L) ? DONE : POST;
                        end
                    end
                end
                POST: begin
                    wrapped_next = wrapped_reg | (fill_reg == DEPTH);
                    if (bus.din_valid) begin
                        wr_en         = 1'b1;
                        wr_ptr_next   = wr_ptr_reg + ADDR_W'(1);
                        post_cnt_next = post_cnt_reg - ONE_L;
                        if (post_cnt_reg == ONE_L)
                            state_next = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            fill_reg      <= '0;
            post_cnt_reg  <= '0;
            wrapped_reg   <= 1'b0;
            trig_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            fill_reg      <= fill_next;
            post_cnt_reg  <= post_cnt_next;
            wrapped_reg   <= wrapped_next;
            trig_addr_reg <= trig_addr_next;
        end
    end

    // Capture memory write port. Contents are never cleared.
    always_ff @(posedge clk) begin
        if (wr_en && !reset)
            mem[wr_ptr_reg] <= bus.din;
    end

    // Read port: registered address, then registered RAM output.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_reg <= '0;
            rd_data_reg <= '0;
        end else begin
            rd_addr_reg <= bus.rd_addr;
            rd_data_reg <= mem[rd_addr_reg];
        end
    end

    assign bus.rd_data = rd_data_reg;
    assign busy        = (state_reg == ARMED) || (state_reg == POST);
    assign done        = (state_reg == DONE);
    assign wrapped     = wrapped_reg;
    assign trig_addr   = trig_addr_reg;
endmodule

// File: tb/tb_htg_ad9213_snapshot.sv
// Directed testbench for htg_ad9213_snapshot. It uses a 16-word buffer
// (ADDR_W = 4) and compares outputs against hand-computed values.
module tb_htg_ad9213_snapshot;
    localparam int ADDR_W = 4;
    localparam int LANES  = 32;
    localparam int SAMP_W = 12;
    localparam int WORD_W = LANES * SAMP_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              arm;
    logic [1:0]        trig_sel;
    logic              trig_ext;
    logic [SAMP_W-1:0] level;
    logic [ADDR_W:0]   post_len;
    logic              busy, done, wrapped;
    logic [ADDR_W-1:0] trig_addr;
    logic [WORD_W-1:0] rdw;
    int                checks = 0;
    int                errors = 0;

    htg_ad9213_snapshot_if #(.ADDR_W(ADDR_W), .LANES(LANES), .SAMP_W(SAMP_W)) bus ();

    htg_ad9213_snapshot #(.ADDR_W(ADDR_W), .LANES(LANES), .SAMP_W(SAMP_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .arm       (arm),
        .trig_sel  (trig_sel),
        .trig_ext  (trig_ext),
        .level     (level),
        .post_len  (post_len),
        .busy      (busy),
        .done      (done),
        .wrapped   (wrapped),
        .trig_addr (trig_addr)
    );

    always #5 clk = ~clk;

    // Ramp word n: lane k holds 32*n + k.
    function automatic logic [WORD_W-1:0] ramp(input int n);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < LANES; k++) w[k*SAMP_W +: SAMP_W] = SAMP_W'(32 * n + k);
        return w;
    endfunction

    // Level-test word n: every lane holds n, except lane 17 on words 4, 6 and 9.
    function automatic logic [WORD_W-1:0] lvl_word(input int n);
        logic [WORD_W-1:0] w;
        logic [SAMP_W-1:0] hot;
        w = '0;
        for (int k = 0; k < LANES; k++) w[k*SAMP_W +: SAMP_W] = SAMP_W'(n);
        hot = SAMP_W'(n);
        if (n == 4) hot = 12'h800;
        if (n == 6) hot = 12'h3FF;
        if (n == 9) hot = 12'h400;
        w[17*SAMP_W +: SAMP_W] = hot;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WORD_W-1:0] w, input logic v, input logic ext);
        bus.din = w; bus.din_valid = v; trig_ext = ext;
        tick();
        $display("word v=%0b ext=%0b lane0=%0h busy=%0b done=%0b", v, ext, w[SAMP_W-1:0], busy, done);
    endtask

    task automatic go_idle();
        bus.din_valid = 1'b0; trig_ext = 1'b0;
    endtask

    task automatic do_arm();
        go_idle();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        $display("arm busy=%0b", busy);
    endtask

    task automatic read_word(input int a, output logic [WORD_W-1:0] d);
        bus.rd_addr = ADDR_W'(a);
        tick();
        tick();
        d = bus.rd_data;
        $display("read addr=%0d lane0=%0h lane31=%0h", a, d[SAMP_W-1:0], d[WORD_W-1 -: SAMP_W]);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b want 0", done); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL rst_wrapped got %0b want 0", wrapped); end
        checks++; if (trig_addr !== '0) begin errors++; $display("FAIL rst_trig_addr got %0d want 0", trig_addr); end
        checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL rst_rd_data got %0h want 0", bus.rd_data); end
    endtask

    task automatic test_immediate();
        trig_sel = 2'd0; post_len = 5'd16;
        do_arm();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL imm_busy_armed got %0b want 1", busy); end
        for (int n = 0; n < 16; n++) begin
            send(ramp(n), 1'b1, 1'b0);
            if (n == 14) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL imm_early_done got %0b want 0", done); end
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL imm_done got %0b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL imm_busy got %0b want 0", busy); end
        checks++; if (trig_addr !== 4'd0) begin errors++; $display("FAIL imm_trig_addr got %0d want 0", trig_addr); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL imm_wrapped got %0b want 0", wrapped); end
        send(ramp(90), 1'b1, 1'b0);
        go_idle();
        read_word(5, rdw);
        checks++; if (rdw !== ramp(5)) begin errors++; $display("FAIL imm_rd5 got %0h want %0h", rdw, ramp(5)); end
        read_word(0, rdw);
        checks++; if (rdw !== ramp(0)) begin errors++; $display("FAIL imm_rd0_after_done got %0h want %0h", rdw, ramp(0)); end
    endtask

    task automatic test_ext();
        trig_sel = 2'd1; post_len = 5'd4;
        do_arm();
        for (int n = 0; n < 24; n++) begin
            send(ramp(n), 1'b1, n == 20);
            if (n == 22) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL ext_early_done got %0b want 0", done); end
            end
        end
        go_idle();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ext_done got %0b want 1", done); end
        checks++; if (trig_addr !== 4'd4) begin errors++; $display("FAIL ext_trig_addr got %0d want 4", trig_addr); end
        checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL ext_wrapped got %0b want 1", wrapped); end
        read_word(8, rdw);
        checks++; if (rdw !== ramp(8)) begin errors++; $display("FAIL ext_oldest got %0h want %0h", rdw, ramp(8)); end
        read_word(4, rdw);
        checks++; if (rdw !== ramp(20)) begin errors++; $display("FAIL ext_trig_word got %0h want %0h", rdw, ramp(20)); end
    endtask

    task automatic test_level();
        trig_sel = 2'd2; level = 12'h400; post_len = 5'd2;
        do_arm();
        for (int n = 0; n < 11; n++) begin
            send(lvl_word(n), 1'b1, 1'b0);
            if (n == 8) begin
                checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL lvl_no_early_trig got busy=%0b done=%0b want busy=1 done=0", busy, done); end
            end
        end
        go_idle();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL lvl_done got %0b want 1", done); end
        checks++; if (trig_addr !== 4'd9) begin errors++; $display("FAIL lvl_trig_addr got %0d want 9", trig_addr); end
        read_word(9, rdw);
        checks++; if (rdw !== lvl_word(9)) begin errors++; $display("FAIL lvl_rd9 got %0h want %0h", rdw, lvl_word(9)); end
    endtask

    task automatic test_post_len();
        trig_sel = 2'd0; post_len = 5'd0;
        do_arm();
        send(ramp(30), 1'b1, 1'b0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pl0_done got %0b want 1", done); end
        checks++; if (trig_addr !== 4'd0) begin errors++; $display("FAIL pl0_trig_addr got %0d want 0", trig_addr); end
        send(ramp(31), 1'b1, 1'b0);
        go_idle();
        read_word(0, rdw);
        checks++; if (rdw !== ramp(30)) begin errors++; $display("FAIL pl0_rd0 got %0h want %0h", rdw, ramp(30)); end
        read_word(1, rdw);
        checks++; if (rdw !== lvl_word(1)) begin errors++; $display("FAIL pl0_rd1 got %0h want %0h", rdw, lvl_word(1)); end
        post_len = 5'd31;
        do_arm();
        for (int n = 0; n < 16; n++) begin
            send(ramp(40 + n), 1'b1, 1'b0);
            if (n == 14) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL pl31_early_done got %0b want 0", done); end
            end
        end
        go_idle();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pl31_done got %0b want 1", done); end
        read_word(15, rdw);
        checks++; if (rdw !== ramp(55)) begin errors++; $display("FAIL pl31_rd15 got %0h want %0h", rdw, ramp(55)); end
    endtask

    task automatic test_valid_gaps();
        int v;
        trig_sel = 2'd1; post_len = 5'd6;
        do_arm();
        v = 0;
        for (int i = 0; i < 40 && v < 9; i++) begin
            if (i % 2 == 0) begin
                send(ramp(60 + v), 1'b1, v == 3);
                if (v == 7) begin
                    checks++; if (done !== 1'b0) begin errors++; $display("FAIL gap_early_done got %0b want 0", done); end
                end
                if (v == 8) begin
                    checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done got %0b want 1", done); end
                end
                v++;
            end else begin
                send(ramp(99), 1'b0, 1'b1);
            end
        end
        go_idle();
        checks++; if (trig_addr !== 4'd3) begin errors++; $display("FAIL gap_trig_addr got %0d want 3", trig_addr); end
        read_word(3, rdw);
        checks++; if (rdw !== ramp(63)) begin errors++; $display("FAIL gap_rd3 got %0h want %0h", rdw, ramp(63)); end
        read_word(8, rdw);
        checks++; if (rdw !== ramp(68)) begin errors++; $display("FAIL gap_rd8 got %0h want %0h", rdw, ramp(68)); end
        read_word(9, rdw);
        checks++; if (rdw !== ramp(49)) begin errors++; $display("FAIL gap_rd9_untouched got %0h want %0h", rdw, ramp(49)); end
    endtask

    task automatic test_abort_reset();
        trig_sel = 2'd1; post_len = 5'd8;
        do_arm();
        for (int n = 0; n < 5; n++) send(ramp(100 + n), 1'b1, n == 2);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL abort_in_post got busy=%0b done=%0b want 1/0", busy, done); end
        bus.din = ramp(110); bus.din_valid = 1'b1; trig_ext = 1'b1; arm = 1'b1;
        tick();
        arm = 1'b0;
        $display("re-arm busy=%0b done=%0b", busy, done);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rearm_busy got %0b want 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rearm_done got %0b want 0", done); end
        send(ramp(111), 1'b1, 1'b0);
        send(ramp(112), 1'b1, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rearm_still_armed got %0b want 1", busy); end
        bus.din = ramp(113); bus.din_valid = 1'b1; trig_ext = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        go_idle();
        $display("reset mid-capture busy=%0b done=%0b", busy, done);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mrst_done got %0b want 0", done); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL mrst_wrapped got %0b want 0", wrapped); end
        checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL mrst_rd_data got %0h want 0", bus.rd_data); end
        checks++; if (trig_addr !== 4'd0) begin errors++; $display("FAIL mrst_trig_addr got %0d want 0", trig_addr); end
        read_word(0, rdw);
        checks++; if (rdw !== ramp(111)) begin errors++; $display("FAIL rearm_rd0 got %0h want %0h", rdw, ramp(111)); end
        read_word(5, rdw);
        checks++; if (rdw !== ramp(65)) begin errors++; $display("FAIL arm_word_not_written got %0h want %0h", rdw, ramp(65)); end
        read_word(2, rdw);
        checks++; if (rdw !== ramp(102)) begin errors++; $display("FAIL rst_word_not_written got %0h want %0h", rdw, ramp(102)); end
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; trig_sel = 2'd0; trig_ext = 1'b0;
        level = '0; post_len = '0;
        bus.din = '0; bus.din_valid = 1'b0; bus.rd_addr = '0;
        test_reset();
        test_immediate();
        test_ext();
        test_level();
        test_post_len();
        test_valid_gaps();
        test_abort_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
